// File: rtl/gpio_input_interface_pkg.sv
// gpio_input_interface_pkg
// Purpose : system-wide bus widths and memory response/count encodings used
//           by the GPIO input block, plus a helper that turns an access-size
//           code into a byte count.
// Contents: ADDR_W, WORD_W, MEM_CODE_*, MEM_COUNT_*, count_bytes().
package gpio_input_interface_pkg;

   localparam int ADDR_W      = 32;
   localparam int WORD_W      = 32;
   localparam int MEM_CODE_W  = 2;
   localparam int MEM_COUNT_W = 3;

   // A code of zero is deliberately unused so an undriven bus never
   // aliases a real response.
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_SUCCESS = 2'd1;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 2'd2;

   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 3'd1;
   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 3'd2;
   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd4;

   // Unknown size codes fall back to a single byte.
   function automatic logic [31:0] count_bytes(input logic [MEM_COUNT_W-1:0] cnt);
      case (cnt)
         MEM_COUNT_BYTE: count_bytes = 32'd1;
         MEM_COUNT_HALF: count_bytes = 32'd2;
         MEM_COUNT_WORD: count_bytes = 32'd4;
         default:        count_bytes = 32'd1;
      endcase
   endfunction

endpackage

// File: rtl/gpio_input_interface_if.sv
// gpio_input_interface_if
// Purpose : request bundle of the byte-addressed register bus.
// Signals : i_req_addr (byte address), i_req_wr_data (little-endian write
//           data), i_req_wr_en (1 = write), i_req_count (access size code).
// Modports: master drives the request, slave receives it.
interface gpio_input_interface_if;
   import gpio_input_interface_pkg::*;

   logic [ADDR_W-1:0]      i_req_addr;
   logic [WORD_W-1:0]      i_req_wr_data;
   logic                   i_req_wr_en;
   logic [MEM_COUNT_W-1:0] i_req_count;

   modport master (output i_req_addr, output i_req_wr_data,
                   output i_req_wr_en, output i_req_count);
   modport slave  (input  i_req_addr, input  i_req_wr_data,
                   input  i_req_wr_en, input  i_req_count);
endinterface

// File: rtl/gpio_input_interface_sync_edge.sv
// gpio_sync_edge
// Purpose : two-flop synchronizer per pin plus a history flop for edge
//           detection.
// Ports   : clk, reset (sync, active-high), i_pins (async pins),
//           o_level (synchronized level), o_rise / o_fall (one-cycle edge
//           indications derived from the synchronized level and its history).
module gpio_sync_edge #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_pins,
   output logic [W-1:0] o_level,
   output logic [W-1:0] o_rise,
   output logic [W-1:0] o_fall
);

   logic [W-1:0] s1_q, s1_d;
   logic [W-1:0] s2_q, s2_d;
   logic [W-1:0] s3_q, s3_d;

   // Next state of the synchronizer/history shift chain.
   always_comb begin
      s1_d = i_pins;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // Synchronizer and history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= {W{1'b0}};
         s2_q <= {W{1'b0}};
         s3_q <= {W{1'b0}};
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign o_level = s2_q;
   assign o_rise  = s2_q & ~s3_q;
   assign o_fall  = ~s2_q & s3_q;

endmodule

// File: rtl/gpio_input_interface.sv
// gpio_input_interface
// Purpose : GPIO input block. Exposes per-bank LEVEL bytes and sticky
//           write-one-to-clear RISE/FALL flag bytes in a flat byte space
//           starting at ADDR_START. Reads are combinational.
// Ports   : clk, reset (sync, active-high), req (request bundle, slave),
//           i_gpio_pins (async pins), o_res_rd_data / o_res_code (response,
//           HiZ when the start byte is outside the space), o_edge_pending
//           (registered OR of all flags).
module gpio_input_interface
   import gpio_input_interface_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR_START = {ADDR_W{1'b0}},
   parameter int                BANK_COUNT = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   gpio_input_interface_if.slave      req,
   input  logic [8*BANK_COUNT-1:0]    i_gpio_pins,
   output logic [WORD_W-1:0]          o_res_rd_data,
   output logic [MEM_CODE_W-1:0]      o_res_code,
   output logic                       o_edge_pending
);

   localparam int                GPIO_W      = 8 * BANK_COUNT;
   localparam logic [31:0]       BANK_U      = 32'(BANK_COUNT);
   localparam logic [ADDR_W-1:0] SPACE_BYTES = ADDR_W'(3 * BANK_COUNT);

   logic [GPIO_W-1:0] level_s, rise_det_s, fall_det_s;
   logic [GPIO_W-1:0] rise_q, rise_d, fall_q, fall_d;
   logic [GPIO_W-1:0] rise_clr_s, fall_clr_s;
   logic [1:0]        warm_q, warm_d;
   logic              edge_pending_q, edge_pending_d;

   logic [ADDR_W-1:0] off_s;
   logic [ADDR_W:0]   last_s;
   logic [31:0]       size_s, idx_s;
   logic              start_in_s, all_in_s;
   logic [WORD_W-1:0] rd_data_s;

   gpio_sync_edge #(.W(GPIO_W)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_pins  (i_gpio_pins),
      .o_level (level_s),
      .o_rise  (rise_det_s),
      .o_fall  (fall_det_s)
   );

   // Address decode: start byte in range, and whole access in range.
   always_comb begin
      off_s  = req.i_req_addr - ADDR_START;
      size_s = count_bytes(req.i_req_count);
      last_s = {1'b0, off_s} + (ADDR_W+1)'(size_s - 32'd1);
      if ((req.i_req_addr >= ADDR_START) && (off_s < SPACE_BYTES)) begin
         start_in_s = 1'b1;
      end else begin
         start_in_s = 1'b0;
      end
      if (start_in_s && (last_s < {1'b0, SPACE_BYTES})) begin
         all_in_s = 1'b1;
      end else begin
         all_in_s = 1'b0;
      end
   end

   // Per-byte read mux and W1C masks; each byte follows its own region.
   always_comb begin
      rd_data_s  = {WORD_W{1'b0}};
      rise_clr_s = {GPIO_W{1'b0}};
      fall_clr_s = {GPIO_W{1'b0}};
      idx_s      = 32'd0;
      for (int n = 0; n < 4; n++) begin
         idx_s = 32'(off_s) + 32'(n);
         if (all_in_s && (32'(n) < size_s)) begin
            if (idx_s < BANK_U) begin
               rd_data_s[8*n +: 8] = level_s[8*idx_s +: 8];
            end else if (idx_s < 32'd2 * BANK_U) begin
               rd_data_s[8*n +: 8] = rise_q[8*(idx_s - BANK_U) +: 8];
               if (req.i_req_wr_en) begin
                  rise_clr_s[8*(idx_s - BANK_U) +: 8] = req.i_req_wr_data[8*n +: 8];
               end else begin
                  rise_clr_s[8*(idx_s - BANK_U) +: 8] = 8'h00;
               end
            end else begin
               rd_data_s[8*n +: 8] = fall_q[8*(idx_s - 32'd2 * BANK_U) +: 8];
               if (req.i_req_wr_en) begin
                  fall_clr_s[8*(idx_s - 32'd2 * BANK_U) +: 8] = req.i_req_wr_data[8*n +: 8];
               end else begin
                  fall_clr_s[8*(idx_s - 32'd2 * BANK_U) +: 8] = 8'h00;
               end
            end
         end else begin
            rd_data_s[8*n +: 8] = 8'h00;
         end
      end
   end

   // Flag next state: set wins over W1C; edges ignored until warm-up ends.
   always_comb begin
      if (warm_q != 2'd0) begin
         warm_d = warm_q - 2'd1;
         rise_d = rise_q & ~rise_clr_s;
         fall_d = fall_q & ~fall_clr_s;
      end else begin
         warm_d = 2'd0;
         rise_d = (rise_q & ~rise_clr_s) | rise_det_s;
         fall_d = (fall_q & ~fall_clr_s) | fall_det_s;
      end
      edge_pending_d = (|rise_q) | (|fall_q);
   end

   // Flag, warm-up and pending registers; reset overrides writes and edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         rise_q         <= {GPIO_W{1'b0}};
         fall_q         <= {GPIO_W{1'b0}};
         warm_q         <= 2'd3;
         edge_pending_q <= 1'b0;
      end else begin
         rise_q         <= rise_d;
         fall_q         <= fall_d;
         warm_q         <= warm_d;
         edge_pending_q <= edge_pending_d;
      end
   end

   // The synchronizer may not yet be cleared in the first reset cycle,
   // so read data is forced to zero for the whole reset window.
   assign o_res_rd_data  = start_in_s ? (reset ? {WORD_W{1'b0}} : rd_data_s)
                                      : {WORD_W{1'bz}};
   assign o_res_code     = start_in_s ? (all_in_s ? MEM_CODE_SUCCESS : MEM_CODE_INVALID)
                                      : {MEM_CODE_W{1'bz}};
   assign o_edge_pending = edge_pending_q;

endmodule
